entropy_pool: RTL and testbench

//  Parametrised successor to the fixed 4-ring entropy source. Instantiates NUM_CH ring_counter

---
 rtl/entropy_pool.sv | 267 ++++++++++++++++++++++++++
 tb/tb_entropy_pool.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/entropy_pool.sv
// Ring-oscillator entropy pool: folded raw samples, rotate-XOR whitening, repetition health test, output FIFO.
// Optional fail counter output enabled by defining ENTROPY_FAIL_CNT_EN.

module ring_counter #(
    parameter int DELAY = 79
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] count_o
);
    localparam int DW = $clog2(DELAY + 1);

    logic [DW-1:0] div_q;
    logic [15:0]   count_q;

    // Behavioural stand-in for the oscillator: one count per DELAY cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            count_q <= 16'd0;
        end else if (div_q == DW'(DELAY - 1)) begin
            div_q   <= '0;
            count_q <= count_q + 16'd1;
        end else begin
            div_q   <= div_q + DW'(1);
        end
    end

    assign count_o = count_q;
endmodule

module entropy_pool #(
    parameter int NUM_CH     = 4,
    parameter int DELAY_BASE = 79,
    parameter int DELAY_STEP = 6,
    parameter int OUT_W      = 8,
    parameter int ACC_CYCLES = 8,
    parameter int WARMUP     = 64,
    parameter int REP_LIMIT  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             test_mode,
    input  logic [OUT_W-1:0] test_raw,
    output logic [OUT_W-1:0] dat,
    output logic             dat_valid,
    input  logic             dat_ready,
    output logic             health_fail,
`ifdef ENTROPY_FAIL_CNT_EN
    output logic [7:0]       fail_cnt,
`endif
    output logic             ovf
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WARM   = 2'd1;
    localparam logic [1:0] ACCUM  = 2'd2;
    localparam logic [1:0] FAILED = 2'd3;

    localparam int SCW = $clog2(ACC_CYCLES + 1);
    localparam int WCW = $clog2(WARMUP + 2);
    localparam int RCW = $clog2(REP_LIMIT + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    function automatic logic [OUT_W-1:0] fold16(input logic [15:0] v);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) r[b % OUT_W] = r[b % OUT_W] ^ v[b];
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] bitrev(input logic [OUT_W-1:0] v);
        logic [OUT_W-1:0] r;
        for (int i = 0; i < OUT_W; i++) r[i] = v[OUT_W-1-i];
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] rotl1(input logic [OUT_W-1:0] v);
        return {v[OUT_W-2:0], v[OUT_W-1]};
    endfunction

    logic             rst_hi_s;
    logic [15:0]      ch_cnt_s [NUM_CH];
    logic [OUT_W-1:0] ring_raw_s, raw_s, acc_n_s;
    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d, prev_q, prev_d;
    logic [SCW-1:0]   sample_q, sample_d;
    logic [WCW-1:0]   warm_q, warm_d;
    logic [RCW-1:0]   rep_q, rep_d, rep_upd_s;
    logic             push_s, fail_s, pop_s, we_s, ovf_d, full_s;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0] head_d, dat_q;
    logic             dat_valid_q, health_fail_q, ovf_q;

    assign rst_hi_s = ~rst;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ring_counter #(.DELAY(DELAY_BASE + DELAY_STEP * g)) u_rc (
            .clk     (clk),
            .rst     (rst_hi_s),
            .count_o (ch_cnt_s[g])
        );
    end

    // Fold each channel to OUT_W bits; odd channels are mirrored before combining.
    always_comb begin
        ring_raw_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((c % 2) == 1) ring_raw_s = ring_raw_s ^ bitrev(fold16(ch_cnt_s[c]));
            else              ring_raw_s = ring_raw_s ^ fold16(ch_cnt_s[c]);
        end
    end

    assign raw_s   = test_mode ? test_raw : ring_raw_s;
    assign acc_n_s = rotl1(acc_q) ^ raw_s;
    assign pop_s   = dat_valid_q & dat_ready;

    // Sequencing, whitening and health test.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sample_d  = sample_q;
        warm_d    = warm_q;
        rep_d     = rep_q;
        prev_d    = prev_q;
        rep_upd_s = rep_q;
        push_s    = 1'b0;
        fail_s    = 1'b0;
        if (!en) begin
            state_d  = IDLE;
            acc_d    = '0;
            sample_d = '0;
            warm_d   = '0;
            rep_d    = '0;
        end else begin
            if (state_q == WARM || state_q == ACCUM) begin
                if (raw_s == prev_q) rep_upd_s = (rep_q == RCW'(REP_LIMIT)) ? rep_q : rep_q + RCW'(1);
                else                 rep_upd_s = RCW'(1);
                rep_d  = rep_upd_s;
                prev_d = raw_s;
                fail_s = (rep_upd_s >= RCW'(REP_LIMIT));
            end else begin
                rep_d = rep_q;
            end
            case (state_q)
                IDLE: begin
                    warm_d = '0;
                    if (WARMUP == 0) state_d = ACCUM;
                    else             state_d = WARM;
                end
                WARM: begin
                    if (fail_s) begin
                        state_d = FAILED;
                    end else if (int'(warm_q) >= WARMUP - 1) begin
                        state_d = ACCUM;
                        warm_d  = '0;
                    end else begin
                        warm_d  = warm_q + WCW'(1);
                    end
                end
                ACCUM: begin
                    if (fail_s) begin
                        state_d  = FAILED;
                        acc_d    = '0;
                        sample_d = '0;
                    end else if (sample_q == SCW'(ACC_CYCLES - 1)) begin
                        push_s   = 1'b1;
                        acc_d    = '0;
                        sample_d = '0;
                    end else begin
                        acc_d    = acc_n_s;
                        sample_d = sample_q + SCW'(1);
                    end
                end
                FAILED:  state_d = FAILED;
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; entry into FAILED flushes, overriding any push or pop.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        we_s   = 1'b0;
        ovf_d  = 1'b0;
        full_s = (cnt_q == CW'(FIFO_DEPTH));
        if (fail_s) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_s && (!full_s || pop_s)) begin
                we_s = 1'b1;
                wr_d = wr_q + PW'(1);
            end else if (push_s) begin
                ovf_d = 1'b1;
            end else begin
                we_s = 1'b0;
            end
            if (pop_s) rd_d = rd_q + PW'(1);
            else       rd_d = rd_q;
            cnt_d = cnt_q + CW'(we_s) - CW'(pop_s);
        end
        if (cnt_d == '0)                  head_d = '0;
        else if (we_s && (rd_d == wr_q))  head_d = acc_n_s;
        else                              head_d = mem_q[rd_d];
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            sample_q      <= '0;
            warm_q        <= '0;
            rep_q         <= '0;
            prev_q        <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            dat_q         <= '0;
            dat_valid_q   <= 1'b0;
            health_fail_q <= 1'b0;
            ovf_q         <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            sample_q      <= sample_d;
            warm_q        <= warm_d;
            rep_q         <= rep_d;
            prev_q        <= prev_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
            dat_q         <= head_d;
            dat_valid_q   <= (cnt_d != '0);
            health_fail_q <= (state_d == FAILED);
            ovf_q         <= ovf_d;
            if (we_s) mem_q[wr_q] <= acc_n_s;
        end
    end

`ifdef ENTROPY_FAIL_CNT_EN
    logic [7:0] fail_cnt_q;

    // Count entries into FAILED, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                                    fail_cnt_q <= 8'd0;
        else if (fail_s && state_q != FAILED && fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
        else                                                         fail_cnt_q <= fail_cnt_q;
    end

    assign fail_cnt = fail_cnt_q;
`endif

    assign dat         = dat_q;
    assign dat_valid   = dat_valid_q;
    assign health_fail = health_fail_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_entropy_pool.sv
// Directed bench for entropy_pool in test_mode with WARMUP=0; expected words are hand-derived.
// Whitened word of raw sequence (base|0..7) is 0x0F ^ (parity(base) ? 0xFF : 0x00).

module tb_entropy_pool;
    logic       clk = 1'b0;
    logic       rst, en, test_mode, dat_ready, health_fail, dat_valid, ovf;
    logic [7:0] test_raw, dat;
`ifdef ENTROPY_FAIL_CNT_EN
    logic [7:0] fail_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    entropy_pool #(.WARMUP(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .test_mode   (test_mode),
        .test_raw    (test_raw),
        .dat         (dat),
        .dat_valid   (dat_valid),
        .dat_ready   (dat_ready),
        .health_fail (health_fail),
`ifdef ENTROPY_FAIL_CNT_EN
        .fail_cnt    (fail_cnt),
`endif
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] v);
        test_raw = v;
        tick();
    endtask

    task automatic word(input logic [7:0] base);
        for (int i = 0; i < 8; i++) sample(base | 8'(i));
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_eq(tag, {8'h00, dat}, {8'h00, exp});
        dat_ready = 1'b1;
        tick();
        dat_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; test_mode = 1'b1; dat_ready = 1'b0; test_raw = 8'h00;
        #12;
        check_eq("rst_dat",   {8'h00, dat}, 16'h0000);
        check_eq("rst_valid", {15'd0, dat_valid}, 16'd0);
        check_eq("rst_fail",  {15'd0, health_fail}, 16'd0);
        check_eq("rst_ovf",   {15'd0, ovf}, 16'd0);
        rst = 1'b1;
        tick();

        // First word: raw 0..7 -> 0x0F
        en = 1'b1; tick();
        for (int i = 0; i < 7; i++) sample(8'(i));
        check_eq("w1_not_yet", {15'd0, dat_valid}, 16'd0);
        sample(8'h07);
        check_eq("w1_valid", {15'd0, dat_valid}, 16'd1);
        check_eq("w1_dat",   {8'h00, dat}, 16'h000F);
        en = 1'b0; tick();
        check_eq("w1_kept_idle", {15'd0, dat_valid}, 16'd1);
        pop_check("w1_pop", 8'h0F);
        check_eq("w1_empty", {15'd0, dat_valid}, 16'd0);
        check_eq("w1_empty_dat", {8'h00, dat}, 16'h0000);

        // Repetition failure: 16 x 0x5A
        en = 1'b1; tick();
        for (int i = 0; i < 8; i++) sample(8'h5A);
        check_eq("rep_word_valid", {15'd0, dat_valid}, 16'd1);
        check_eq("rep_word_dat",   {8'h00, dat}, 16'h0000);
        for (int i = 0; i < 7; i++) sample(8'h5A);
        check_eq("rep_15_ok", {15'd0, health_fail}, 16'd0);
        sample(8'h5A);
        check_eq("rep_16_fail",  {15'd0, health_fail}, 16'd1);
        check_eq("rep_flushed",  {15'd0, dat_valid}, 16'd0);
        sample(8'h33);
        check_eq("rep_stuck", {15'd0, health_fail}, 16'd1);
        en = 1'b0; tick();
        check_eq("rep_exit", {15'd0, health_fail}, 16'd0);
        check_eq("rep_exit_empty", {15'd0, dat_valid}, 16'd0);

        // Overflow: five words, no consumer
        en = 1'b1; tick();
        word(8'h00); check_eq("of_w1_ovf", {15'd0, ovf}, 16'd0);
        word(8'h10); check_eq("of_w2_ovf", {15'd0, ovf}, 16'd0);
        word(8'h30); check_eq("of_w3_ovf", {15'd0, ovf}, 16'd0);
        word(8'h70); check_eq("of_w4_ovf", {15'd0, ovf}, 16'd0);
        check_eq("of_head", {8'h00, dat}, 16'h000F);
        for (int i = 0; i < 7; i++) sample(8'hF0 | 8'(i));
        check_eq("of_w5_pre", {15'd0, ovf}, 16'd0);
        sample(8'hF7);
        check_eq("of_w5_ovf", {15'd0, ovf}, 16'd1);
        check_eq("of_valid",  {15'd0, dat_valid}, 16'd1);
        en = 1'b0; tick();
        check_eq("of_pulse_end", {15'd0, ovf}, 16'd0);

        // Full FIFO, pop coincides with the completing push
        en = 1'b1; tick();
        for (int i = 0; i < 7; i++) sample(8'h30 | 8'(i));
        dat_ready = 1'b1;
        sample(8'h37);
        dat_ready = 1'b0;
        check_eq("fp_ovf",   {15'd0, ovf}, 16'd0);
        check_eq("fp_valid", {15'd0, dat_valid}, 16'd1);
        en = 1'b0; tick();
        pop_check("fp_pop0", 8'hF0);
        pop_check("fp_pop1", 8'h0F);
        pop_check("fp_pop2", 8'hF0);
        pop_check("fp_pop3", 8'h0F);
        check_eq("fp_count4", {15'd0, dat_valid}, 16'd0);

        // Asynchronous reset mid-accumulation
        en = 1'b1; tick();
        word(8'h10);
        word(8'h30);
        sample(8'h50); sample(8'h51); sample(8'h52);
        check_eq("ar_pre_valid", {15'd0, dat_valid}, 16'd1);
        check_eq("ar_pre_dat",   {8'h00, dat}, 16'h00F0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_valid", {15'd0, dat_valid}, 16'd0);
        check_eq("ar_dat",   {8'h00, dat}, 16'h0000);
        rst = 1'b1; en = 1'b0;
        tick();
        check_eq("ar_after", {15'd0, dat_valid}, 16'd0);

`ifdef ENTROPY_FAIL_CNT_EN
        check_eq("fc_zero", {8'h00, fail_cnt}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            en = 1'b1; tick();
            for (int i = 0; i < 16; i++) sample(8'hA5);
            en = 1'b0; tick();
        end
        check_eq("fc_three", {8'h00, fail_cnt}, 16'd3);
        rst = 1'b0; #1;
        check_eq("fc_rst", {8'h00, fail_cnt}, 16'd0);
        rst = 1'b1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
